mult_bus_master: RTL and testbench

- Bus initiator that drives the multiplier peripheral (peripheral_mult) over the peripheral bus (cs/addr/rd/wr/data). It is the host-side counterpart of that peripheral.
- Takes an operand pair over a valid/ready handshake and runs the full access sequence: write A, write B, pulse init, poll done, read result.
- Returns the 32-bit product over a valid/ready handshake.
- Sits between a core-side requester and one peripheral slot.

---
 rtl/mult_bus_pkg.sv | 37 +++
 rtl/bus_access_seq.sv | 74 +++++++
 rtl/mult_bus_master.sv | 174 +++++++++++++++++
 tb/tb_mult_bus_master.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_bus_pkg.sv
// Shared definitions for the multiplier bus initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the sequencer state encoding, the peripheral register map
// defaults and the values written to the init control register.
package mult_bus_pkg;

    localparam int ADDR_W  = 5;
    localparam int WDATA_W = 16;
    localparam int RDATA_W = 32;

    // Default register offsets inside the multiplier peripheral slot.
    localparam logic [ADDR_W-1:0] DEF_ADDR_A    = 5'h04;
    localparam logic [ADDR_W-1:0] DEF_ADDR_B    = 5'h08;
    localparam logic [ADDR_W-1:0] DEF_ADDR_INIT = 5'h0C;
    localparam logic [ADDR_W-1:0] DEF_ADDR_RES  = 5'h10;
    localparam logic [ADDR_W-1:0] DEF_ADDR_DONE = 5'h14;

    // Init is a level in the peripheral: raise then lower to start one run.
    localparam logic [WDATA_W-1:0] INIT_ON  = 16'h0001;
    localparam logic [WDATA_W-1:0] INIT_OFF = 16'h0000;

    typedef enum logic [3:0] {
        IDLE,
        WR_A,
        WR_B,
        INIT1,
        INIT0,
        POLL,
        POLL_CHK,
        RES_RD,
        RES_CHK,
        RESP
    } state_t;

endpackage

// File: rtl/bus_access_seq.sv
// Single peripheral bus access: one rd/wr strobe followed by GAP idle cycles.
// Latency: strobe in the cycle acc_start is seen while idle; acc_done in the last idle cycle (or the strobe cycle for GAP=0 writes).
// Backpressure: acc_start is ignored while an access is still counting down; the caller holds it until acc_done.
//
// Ports: clk, rst (async, active high); acc_start/acc_is_rd/acc_addr/acc_wdata
// describe the access; acc_done/acc_rdata report completion and read data;
// cs/rd/wr/addr/bus_wdata/bus_rdata are the peripheral bus.
module bus_access_seq
    import mult_bus_pkg::*;
#(
    parameter int GAP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                acc_start,
    input  logic                acc_is_rd,
    input  logic [ADDR_W-1:0]   acc_addr,
    input  logic [WDATA_W-1:0]  acc_wdata,
    output logic                acc_done,
    output logic [RDATA_W-1:0]  acc_rdata,
    output logic                cs,
    output logic                rd,
    output logic                wr,
    output logic [ADDR_W-1:0]   addr,
    output logic [WDATA_W-1:0]  bus_wdata,
    input  logic [RDATA_W-1:0]  bus_rdata
);

    // Reads always need one cycle after the strobe to sample the peripheral,
    // so a zero gap still costs one cycle for a read.
    localparam logic [3:0] WR_POST = 4'(GAP);
    localparam logic [3:0] RD_POST = (GAP == 0) ? 4'd1 : 4'(GAP);

    logic [3:0]         left_cnt;   // post-strobe cycles still to run; 0 = idle
    logic               sample_q;   // current cycle is the read sample cycle
    logic [RDATA_W-1:0] rdata_q;
    logic               strobe;
    logic [3:0]         post;

    assign strobe = acc_start && (left_cnt == 4'd0);
    assign post   = acc_is_rd ? RD_POST : WR_POST;

    assign acc_done = (strobe && (post == 4'd0)) || (left_cnt == 4'd1);

    // During the sample cycle the caller may finish on the same edge that
    // captures the data, so pass the live bus value through.
    assign acc_rdata = sample_q ? bus_rdata : rdata_q;

    assign cs        = strobe;
    assign rd        = strobe && acc_is_rd;
    assign wr        = strobe && !acc_is_rd;
    assign addr      = strobe ? acc_addr : '0;
    assign bus_wdata = (strobe && !acc_is_rd) ? acc_wdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_cnt <= 4'd0;
            sample_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (strobe && (post != 4'd0)) begin
                left_cnt <= post;
                sample_q <= acc_is_rd;
            end else if (left_cnt != 4'd0) begin
                left_cnt <= left_cnt - 4'd1;
                sample_q <= 1'b0;
            end
            if (sample_q) begin
                rdata_q <= bus_rdata;
            end
        end
    end

endmodule

// File: rtl/mult_bus_master.sv
// Bus initiator for the multiplier peripheral: write A, write B, pulse init, poll done, read product.
// Latency: with GAP=1 and done on first poll, WR_A strobe 1 cycle after accept, result strobe 10 later, res_valid 2 after that.
// Backpressure: req_ready only in IDLE; RESP holds res_valid/res_data/res_err until res_ready.
//
// Ports: clk, rst (async, active high); op_a/op_b/req_valid/req_ready request
// side; res_data/res_err/res_valid/res_ready response side (res_err flags a
// done-poll timeout); cs/addr/rd/wr/bus_wdata/bus_rdata peripheral bus.
module mult_bus_master
    import mult_bus_pkg::*;
#(
    parameter logic [4:0] ADDR_A    = DEF_ADDR_A,
    parameter logic [4:0] ADDR_B    = DEF_ADDR_B,
    parameter logic [4:0] ADDR_INIT = DEF_ADDR_INIT,
    parameter logic [4:0] ADDR_RES  = DEF_ADDR_RES,
    parameter logic [4:0] ADDR_DONE = DEF_ADDR_DONE,
    parameter int         GAP       = 1,
    parameter int         POLL_MAX  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        cs,
    output logic [4:0]  addr,
    output logic        rd,
    output logic        wr,
    output logic [15:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam logic [16:0] POLL_LIM = 17'(POLL_MAX);

    state_t        state, state_nxt;
    logic [15:0]   op_a_q, op_b_q;
    logic [15:0]   poll_cnt, poll_inc;
    logic          poll_timeout;

    logic          acc_start, acc_is_rd, acc_done;
    logic [4:0]    acc_addr;
    logic [15:0]   acc_wdata;
    logic [31:0]   acc_rdata;

    bus_access_seq #(.GAP(GAP)) u_seq (
        .clk       (clk),
        .rst       (rst),
        .acc_start (acc_start),
        .acc_is_rd (acc_is_rd),
        .acc_addr  (acc_addr),
        .acc_wdata (acc_wdata),
        .acc_done  (acc_done),
        .acc_rdata (acc_rdata),
        .cs        (cs),
        .rd        (rd),
        .wr        (wr),
        .addr      (addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    // Saturating poll count; the timeout compares the count this poll would reach.
    assign poll_inc     = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
    assign poll_timeout = ({1'b0, poll_inc} >= POLL_LIM);

    assign req_ready = (state == IDLE);
    assign res_valid = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write states keep acc_start high for the whole access; the sequencer
    // ignores it until the gap has run out. Reads split into a strobe state
    // and a check state that waits for the sampled word.
    always_comb begin
        state_nxt = state;
        acc_start = 1'b0;
        acc_is_rd = 1'b0;
        acc_addr  = 5'd0;
        acc_wdata = 16'd0;
        case (state)
            IDLE: begin
                if (req_valid) state_nxt = WR_A;
            end
            WR_A: begin
                acc_start = 1'b1;
                acc_addr  = ADDR_A;
                acc_wdata = op_a_q;
                if (acc_done) state_nxt = WR_B;
            end
            WR_B: begin
                acc_start = 1'b1;
                acc_addr  = ADDR_B;
                acc_wdata = op_b_q;
                if (acc_done) state_nxt = INIT1;
            end
            INIT1: begin
                acc_start = 1'b1;
                acc_addr  = ADDR_INIT;
                acc_wdata = INIT_ON;
                if (acc_done) state_nxt = INIT0;
            end
            INIT0: begin
                acc_start = 1'b1;
                acc_addr  = ADDR_INIT;
                acc_wdata = INIT_OFF;
                if (acc_done) state_nxt = POLL;
            end
            POLL: begin
                acc_start = 1'b1;
                acc_is_rd = 1'b1;
                acc_addr  = ADDR_DONE;
                state_nxt = POLL_CHK;
            end
            POLL_CHK: begin
                if (acc_done) begin
                    if (acc_rdata[0])      state_nxt = RES_RD;
                    else if (poll_timeout) state_nxt = RESP;
                    else                   state_nxt = POLL;
                end
            end
            RES_RD: begin
                acc_start = 1'b1;
                acc_is_rd = 1'b1;
                acc_addr  = ADDR_RES;
                state_nxt = RES_CHK;
            end
            RES_CHK: begin
                if (acc_done) state_nxt = RESP;
            end
            RESP: begin
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q   <= 16'd0;
            op_b_q   <= 16'd0;
            poll_cnt <= 16'd0;
            res_data <= 32'd0;
            res_err  <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                op_a_q   <= op_a;
                op_b_q   <= op_b;
                poll_cnt <= 16'd0;
            end
            if (state == POLL_CHK && acc_done && !acc_rdata[0]) begin
                poll_cnt <= poll_inc;
                if (poll_timeout) begin
                    res_data <= 32'd0;
                    res_err  <= 1'b1;
                end
            end
            if (state == RES_CHK && acc_done) begin
                res_data <= acc_rdata;
                res_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mult_bus_master.sv
// Bench for mult_bus_master: two instances (GAP=1/POLL_MAX=64 and GAP=0/POLL_MAX=4)
// each driving a behavioural multiplier peripheral with a configurable done delay.
// Table of directed operand vectors plus hand-written multi-cycle sequences.
module tb_mult_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s       [2];
    logic [15:0] op_a_s      [2];
    logic [15:0] op_b_s      [2];
    logic        req_valid_s [2];
    logic        req_ready_s [2];
    logic [31:0] res_data_s  [2];
    logic        res_err_s   [2];
    logic        res_valid_s [2];
    logic        res_ready_s [2];
    logic        cs_s        [2];
    logic [4:0]  addr_s      [2];
    logic        rd_s        [2];
    logic        wr_s        [2];
    logic [15:0] wdata_s     [2];
    logic [31:0] rdata_s     [2] = '{32'd0, 32'd0};

    mult_bus_master #(.GAP(1), .POLL_MAX(64)) u_gap1 (
        .clk(clk), .rst(rst_s[0]), .op_a(op_a_s[0]), .op_b(op_b_s[0]),
        .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]),
        .res_data(res_data_s[0]), .res_err(res_err_s[0]),
        .res_valid(res_valid_s[0]), .res_ready(res_ready_s[0]),
        .cs(cs_s[0]), .addr(addr_s[0]), .rd(rd_s[0]), .wr(wr_s[0]),
        .bus_wdata(wdata_s[0]), .bus_rdata(rdata_s[0])
    );

    mult_bus_master #(.GAP(0), .POLL_MAX(4)) u_gap0 (
        .clk(clk), .rst(rst_s[1]), .op_a(op_a_s[1]), .op_b(op_b_s[1]),
        .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]),
        .res_data(res_data_s[1]), .res_err(res_err_s[1]),
        .res_valid(res_valid_s[1]), .res_ready(res_ready_s[1]),
        .cs(cs_s[1]), .addr(addr_s[1]), .rd(rd_s[1]), .wr(wr_s[1]),
        .bus_wdata(wdata_s[1]), .bus_rdata(rdata_s[1])
    );

    // ---------------- peripheral model ----------------
    int          done_delay [2];
    logic [15:0] m_a    [2] = '{16'd0, 16'd0};
    logic [15:0] m_b    [2] = '{16'd0, 16'd0};
    logic        m_run  [2] = '{1'b0, 1'b0};
    logic        m_done [2] = '{1'b0, 1'b0};
    int          m_cnt  [2] = '{0, 0};

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (cs_s[g] && wr_s[g]) begin
                if (addr_s[g] == 5'h04) m_a[g] <= wdata_s[g];
                else if (addr_s[g] == 5'h08) m_b[g] <= wdata_s[g];
                else if (addr_s[g] == 5'h0C && wdata_s[g][0]) begin
                    m_run[g]  <= 1'b1;
                    m_cnt[g]  <= 0;
                    m_done[g] <= 1'b0;
                end
            end else if (m_run[g]) begin
                m_cnt[g] <= m_cnt[g] + 1;
                if (m_cnt[g] + 1 >= done_delay[g]) m_done[g] <= 1'b1;
            end
            if (cs_s[g] && rd_s[g]) begin
                // Upper bits of the done word carry junk that must be ignored.
                if (addr_s[g] == 5'h14)      rdata_s[g] <= {16'hA5A5, 15'h1234, m_done[g]};
                else if (addr_s[g] == 5'h10) rdata_s[g] <= {16'h0, m_a[g]} * {16'h0, m_b[g]};
                else                         rdata_s[g] <= 32'hDEAD_BEEF;
            end
        end
    end

    // ---------------- bus monitor ----------------
    int          cyc = 0;
    int          n_rd14 [2] = '{0, 0};
    int          n_rd10 [2] = '{0, 0};
    int          n_acc  [2] = '{0, 0};
    int          n_cs   [2] = '{0, 0};
    int          viol   [2] = '{0, 0};
    int          acc_cyc   [2] = '{0, 0};
    int          wra_cyc   [2] = '{0, 0};
    int          res_cyc   [2] = '{0, 0};
    int          vrise_cyc [2] = '{0, 0};
    int          hs_cyc    [2] = '{0, 0};
    logic        prev_vld  [2] = '{1'b0, 1'b0};
    logic [20:0] wr_log [$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++) begin
            if (req_valid_s[g] && req_ready_s[g]) begin
                n_acc[g]   <= n_acc[g] + 1;
                acc_cyc[g] <= cyc;
            end
            if (cs_s[g]) n_cs[g] <= n_cs[g] + 1;
            if ((rd_s[g] && wr_s[g]) || (cs_s[g] && !rd_s[g] && !wr_s[g]) ||
                (!cs_s[g] && (rd_s[g] || wr_s[g] || addr_s[g] != 5'd0 || wdata_s[g] != 16'd0)))
                viol[g] <= viol[g] + 1;
            if (cs_s[g] && wr_s[g] && addr_s[g] == 5'h04) wra_cyc[g] <= cyc;
            if (cs_s[g] && wr_s[g] && g == 0) wr_log.push_back({addr_s[g], wdata_s[g]});
            if (cs_s[g] && rd_s[g] && addr_s[g] == 5'h14) n_rd14[g] <= n_rd14[g] + 1;
            if (cs_s[g] && rd_s[g] && addr_s[g] == 5'h10) begin
                n_rd10[g]  <= n_rd10[g] + 1;
                res_cyc[g] <= cyc;
            end
            if (res_valid_s[g] && !prev_vld[g]) vrise_cyc[g] <= cyc;
            prev_vld[g] <= res_valid_s[g];
            if (res_valid_s[g] && res_ready_s[g]) hs_cyc[g] <= cyc;
        end
    end

    // ---------------- checking helpers ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input int g, input logic [15:0] a, input logic [15:0] b,
                           input int delay, output logic [31:0] r, output logic e,
                           output logic got);
        int n;
        done_delay[g] = delay;
        n = 0;
        while (!req_ready_s[g] && n < 100) begin step(); n++; end
        op_a_s[g] = a;
        op_b_s[g] = b;
        req_valid_s[g] = 1'b1;
        step();
        req_valid_s[g] = 1'b0;
        n = 0;
        while (!res_valid_s[g] && n < 3000) begin step(); n++; end
        got = res_valid_s[g];
        r   = res_data_s[g];
        e   = res_err_s[g];
        res_ready_s[g] = 1'b1;
        step();
        res_ready_s[g] = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          delay;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    localparam int NV = 7;
    vec_t vec [NV];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, r1, r2;
        logic        e, got, ok;
        int          b14, b10, wl, cs0, a0, h1, a2, n;

        vec[0] = '{16'h0005, 16'h000F, 17, 32'h0000_004B, 1'b0};
        vec[1] = '{16'hFFFF, 16'hFFFF,  0, 32'hFFFE_0001, 1'b0};
        vec[2] = '{16'h0003, 16'h0007,  5, 32'h0000_0015, 1'b0};
        vec[3] = '{16'h0000, 16'h1234,  0, 32'h0000_0000, 1'b0};
        vec[4] = '{16'h0001, 16'hFFFF, 30, 32'h0000_FFFF, 1'b0};
        vec[5] = '{16'h8000, 16'h0002,  2, 32'h0001_0000, 1'b0};
        vec[6] = '{16'h1234, 16'h5678, 60, 32'h0626_0060, 1'b0};

        for (int g = 0; g < 2; g++) begin
            rst_s[g] = 1'b1; op_a_s[g] = 16'd0; op_b_s[g] = 16'd0;
            req_valid_s[g] = 1'b0; res_ready_s[g] = 1'b0; done_delay[g] = 0;
        end
        repeat (3) step();

        // Reset values
        chk("rst_req_ready", 32'(req_ready_s[0]), 32'd1);
        chk("rst_res_valid", 32'(res_valid_s[0]), 32'd0);
        chk("rst_res_data", res_data_s[0], 32'd0);
        chk("rst_res_err", 32'(res_err_s[0]), 32'd0);
        chk("rst_bus", 32'({cs_s[0], rd_s[0], wr_s[0], addr_s[0], wdata_s[0]}), 32'd0);
        chk("rst_req_ready_g0", 32'(req_ready_s[1]), 32'd1);
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        step();

        // Table-driven operand vectors on the GAP=1 instance
        for (int i = 0; i < NV; i++) begin
            b14 = n_rd14[0]; b10 = n_rd10[0]; wl = wr_log.size();
            run_txn(0, vec[i].a, vec[i].b, vec[i].delay, r, e, got);
            chk($sformatf("vec%0d_valid", i), 32'(got), 32'd1);
            chk($sformatf("vec%0d_data", i), r, vec[i].exp_res);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vec[i].exp_err));
            chk($sformatf("vec%0d_res_reads", i), n_rd10[0] - b10, 32'd1);
            chk($sformatf("vec%0d_polled", i), 32'(n_rd14[0] > b14), 32'd1);
            if (i == 0) begin
                chk("basic_wr_count", wr_log.size() - wl, 32'd4);
                if (wr_log.size() >= wl + 4) begin
                    chk("basic_wr_a",    32'(wr_log[wl]),     32'({5'h04, 16'h0005}));
                    chk("basic_wr_b",    32'(wr_log[wl + 1]), 32'({5'h08, 16'h000F}));
                    chk("basic_wr_init1", 32'(wr_log[wl + 2]), 32'({5'h0C, 16'h0001}));
                    chk("basic_wr_init0", 32'(wr_log[wl + 3]), 32'({5'h0C, 16'h0000}));
                end
                chk("basic_multi_poll", 32'(n_rd14[0] - b14 >= 2), 32'd1);
            end
            if (i == 1) begin
                chk("lat_accept_to_wra", wra_cyc[0] - acc_cyc[0], 32'd1);
                chk("lat_wra_to_res", res_cyc[0] - wra_cyc[0], 32'd10);
                chk("lat_res_to_valid", vrise_cyc[0] - res_cyc[0], 32'd2);
            end
        end

        // Backpressure on the response; res_ready early and req_valid late are ignored
        done_delay[0] = 0;
        op_a_s[0] = 16'd2; op_b_s[0] = 16'd3;
        req_valid_s[0] = 1'b1; res_ready_s[0] = 1'b1;
        step();
        req_valid_s[0] = 1'b0;
        repeat (4) step();
        res_ready_s[0] = 1'b0;
        n = 0;
        while (!res_valid_s[0] && n < 500) begin step(); n++; end
        chk("bp_valid", 32'(res_valid_s[0]), 32'd1);
        cs0 = n_cs[0]; a0 = n_acc[0]; ok = 1'b1;
        op_a_s[0] = 16'd9; op_b_s[0] = 16'd9; req_valid_s[0] = 1'b1;
        repeat (10) begin
            step();
            if (res_valid_s[0] !== 1'b1 || res_data_s[0] !== 32'd6 ||
                res_err_s[0] !== 1'b0 || req_ready_s[0] !== 1'b0) ok = 1'b0;
        end
        chk("bp_hold_stable", 32'(ok), 32'd1);
        chk("bp_no_bus", n_cs[0] - cs0, 32'd0);
        chk("bp_no_accept", n_acc[0] - a0, 32'd0);
        res_ready_s[0] = 1'b1;
        step();
        req_valid_s[0] = 1'b0; res_ready_s[0] = 1'b0;
        chk("bp_release_req_ready", 32'(req_ready_s[0]), 32'd1);
        chk("bp_release_valid", 32'(res_valid_s[0]), 32'd0);

        // Reset during polling
        done_delay[0] = 32'h7FFF_FFFF;
        op_a_s[0] = 16'h0011; op_b_s[0] = 16'h0022; req_valid_s[0] = 1'b1;
        step();
        req_valid_s[0] = 1'b0;
        n = 0;
        while (!(cs_s[0] && rd_s[0] && addr_s[0] == 5'h14) && n < 200) begin step(); n++; end
        chk("rst_poll_seen", 32'(cs_s[0] && rd_s[0] && addr_s[0] == 5'h14), 32'd1);
        rst_s[0] = 1'b1;
        #1;
        chk("rst_async_bus", 32'({cs_s[0], rd_s[0], wr_s[0], addr_s[0]}), 32'd0);
        chk("rst_async_req_ready", 32'(req_ready_s[0]), 32'd1);
        step();
        rst_s[0] = 1'b0;
        step();
        run_txn(0, 16'd3, 16'd7, 0, r, e, got);
        chk("post_rst_valid", 32'(got), 32'd1);
        chk("post_rst_data", r, 32'h0000_0015);
        chk("post_rst_err", 32'(e), 32'd0);

        // Timeout on the GAP=0 / POLL_MAX=4 instance
        b14 = n_rd14[1]; b10 = n_rd10[1];
        run_txn(1, 16'h00AA, 16'h0055, 32'h7FFF_FFFF, r, e, got);
        chk("to_valid", 32'(got), 32'd1);
        chk("to_err", 32'(e), 32'd1);
        chk("to_data", r, 32'd0);
        chk("to_polls", n_rd14[1] - b14, 32'd4);
        chk("to_no_res_rd", n_rd10[1] - b10, 32'd0);

        // Back-to-back with req_valid held, GAP=0
        done_delay[1] = 0;
        op_a_s[1] = 16'h0010; op_b_s[1] = 16'h0010; req_valid_s[1] = 1'b1;
        step();
        op_a_s[1] = 16'h0003; op_b_s[1] = 16'h0004;
        n = 0;
        while (!res_valid_s[1] && n < 500) begin step(); n++; end
        r1 = res_data_s[1];
        res_ready_s[1] = 1'b1;
        step();
        res_ready_s[1] = 1'b0;
        h1 = hs_cyc[1];
        chk("b2b_req_ready", 32'(req_ready_s[1]), 32'd1);
        step();
        req_valid_s[1] = 1'b0;
        a2 = acc_cyc[1];
        chk("b2b_accept_gap", a2 - h1, 32'd1);
        n = 0;
        while (!res_valid_s[1] && n < 500) begin step(); n++; end
        r2 = res_data_s[1];
        res_ready_s[1] = 1'b1;
        step();
        res_ready_s[1] = 1'b0;
        chk("b2b_first", r1, 32'h0000_0100);
        chk("b2b_second", r2, 32'h0000_000C);

        chk("proto_gap1", viol[0], 32'd0);
        chk("proto_gap0", viol[1], 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
